// File: rtl/trace_capture.sv
// trace_capture: on-chip trace buffer for the vector processor.
//
// Records {pc, data} once per cycle while capturing and enable is high.
// Entries drain through a valid/ready read port. Supports stop-when-full
// and circular (overwrite-oldest) modes, plus sticky overflow and a
// saturating sample counter.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable, pc, data  sample strobe and captured payload
//   arm, stop         start (clears buffer/status) / end capture
//   wrap_mode         0 = stop when full, 1 = circular overwrite
//   rd_ready          consumer accepts the head entry
//   rd_valid          buffer not empty
//   rd_pc, rd_data    head entry (undefined while rd_valid = 0)
//   count             entries held
//   capturing, full   status
//   overflow          sticky: an entry was overwritten in wrap mode
//   samples           accepted samples since last arm, saturating
module trace_capture #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [PC_W-1:0]            pc,
    input  logic [DATA_W-1:0]          data,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       wrap_mode,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [PC_W-1:0]            rd_pc,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       capturing,
    output logic                       full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           samples
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_STOPPED = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  samples_q, samples_d;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic is_full, pop, push;

    assign is_full = (count_q == (AW+1)'(DEPTH));
    assign pop     = (count_q != '0) && rd_ready;
    // A full buffer only accepts a write if it may overwrite (wrap) or a
    // pop frees the head slot in the same cycle. In stop-when-full mode the
    // full case is normally already STOPPED; this also covers wrap_mode
    // being dropped while the buffer sits full.
    assign push    = (state_q == S_CAPTURE) && enable &&
                     (!is_full || wrap_mode || pop);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        samples_d  = samples_q;

        if (push) begin
            tail_d = tail_q + AW'(1);
            if (samples_q != '1)
                samples_d = samples_q + CNT_W'(1);
        end

        // Head moves once for a pop, or for an overwrite of the oldest entry;
        // a push+pop on a full buffer reuses the slot the pop just freed.
        if (pop || (push && is_full))
            head_d = head_q + AW'(1);

        if (push && is_full && !pop)
            overflow_d = 1'b1;

        if (push && !pop && !is_full)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);

        case (state_q)
            S_IDLE, S_STOPPED: begin
                if (arm) begin
                    state_d    = S_CAPTURE;
                    head_d     = '0;
                    tail_d     = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    samples_d  = '0;
                end
            end
            S_CAPTURE: begin
                if (stop)
                    state_d = S_STOPPED;
                else if (!wrap_mode && count_d == (AW+1)'(DEPTH))
                    state_d = S_STOPPED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            samples_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            samples_q  <= samples_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[tail_q]   <= pc;
            data_mem[tail_q] <= data;
        end
    end

    assign rd_valid  = (count_q != '0);
    assign rd_pc     = pc_mem[head_q];
    assign rd_data   = data_mem[head_q];
    assign count     = count_q;
    assign capturing = (state_q == S_CAPTURE);
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign samples   = samples_q;
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture at DEPTH=4.
module tb_trace_capture;
    localparam int DATA_W = 64;
    localparam int PC_W   = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst, enable, arm, stop, wrap_mode, rd_ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic              rd_valid, capturing, full, overflow;
    logic [PC_W-1:0]   rd_pc;
    logic [DATA_W-1:0] rd_data;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]  samples;

    int tests = 0;
    int fails = 0;

    trace_capture #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pc(pc), .data(data),
        .arm(arm), .stop(stop), .wrap_mode(wrap_mode), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_data(rd_data), .count(count),
        .capturing(capturing), .full(full), .overflow(overflow), .samples(samples)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic push(input logic [PC_W-1:0] p, input logic [DATA_W-1:0] d);
        enable = 1'b1; pc = p; data = d;
        tick();
        enable = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [PC_W-1:0] p, input logic [DATA_W-1:0] d);
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk({tag, "_pc"},    64'(rd_pc),    64'(p));
        chk({tag, "_data"},  rd_data,       d);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic pulse_arm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; arm = 1'b0; stop = 1'b0;
        wrap_mode = 1'b0; rd_ready = 1'b0; pc = '0; data = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_capt",  64'(capturing), 64'd0);
        chk("rst_full",  64'(full), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_samp",  64'(samples), 64'd0);

        // Basic capture; enable in the arm cycle must be ignored
        wrap_mode = 1'b0;
        enable = 1'b1; pc = 16'h9; data = 64'hdead;
        pulse_arm();
        enable = 1'b0;
        chk("arm_capt",  64'(capturing), 64'd1);
        chk("arm_samp",  64'(samples), 64'd0);
        chk("arm_count", 64'(count), 64'd0);
        push(16'd1, 64'h60);
        chk("push1_valid", 64'(rd_valid), 64'd1);
        push(16'd2, 64'h2400);
        push(16'd3, 64'h9000);
        pulse_stop();
        chk("basic_capt",  64'(capturing), 64'd0);
        chk("basic_count", 64'(count), 64'd3);
        chk("basic_samp",  64'(samples), 64'd3);
        pop_expect("basic_r0", 16'd1, 64'h60);
        pop_expect("basic_r1", 16'd2, 64'h2400);
        pop_expect("basic_r2", 16'd3, 64'h9000);
        chk("basic_empty", 64'(rd_valid), 64'd0);

        // Auto-stop in stop-when-full mode
        pulse_arm();
        for (int i = 1; i <= 6; i++) begin
            push(16'(i), 64'(i));
            if (i == 4) begin
                chk("auto_full", 64'(full), 64'd1);
                chk("auto_capt", 64'(capturing), 64'd0);
            end
        end
        chk("auto_samp",  64'(samples), 64'd4);
        chk("auto_count", 64'(count), 64'd4);
        rd_ready = 1'b1;   // held high: one entry per cycle
        for (int i = 1; i <= 4; i++) begin
            chk("auto_rd", rd_data, 64'(i));
            tick();
        end
        rd_ready = 1'b0;
        chk("auto_empty", 64'(rd_valid), 64'd0);

        // Circular mode
        wrap_mode = 1'b1;
        pulse_arm();
        for (int i = 1; i <= 6; i++) push(16'(i), 64'(i));
        pulse_stop();
        chk("circ_ovf",   64'(overflow), 64'd1);
        chk("circ_count", 64'(count), 64'd4);
        chk("circ_samp",  64'(samples), 64'd6);
        pop_expect("circ_r0", 16'd3, 64'd3);
        pop_expect("circ_r1", 16'd4, 64'd4);
        pop_expect("circ_r2", 16'd5, 64'd5);
        pop_expect("circ_r3", 16'd6, 64'd6);

        // Re-arm clears sticky overflow; then push+pop while full in wrap mode
        pulse_arm();
        chk("rearm_ovf",  64'(overflow), 64'd0);
        chk("rearm_samp", 64'(samples), 64'd0);
        for (int i = 0; i < 4; i++) push(16'(8'h10 + i), 64'(8'h10 + i));
        chk("pp_full", 64'(full), 64'd1);
        enable = 1'b1; pc = 16'h14; data = 64'h14; rd_ready = 1'b1;
        #1;
        chk("pp_old_head", rd_data, 64'h10);
        tick();
        enable = 1'b0; rd_ready = 1'b0;
        chk("pp_count", 64'(count), 64'd4);
        chk("pp_ovf",   64'(overflow), 64'd0);
        pulse_stop();
        pop_expect("pp_r0", 16'h11, 64'h11);
        pop_expect("pp_r1", 16'h12, 64'h12);
        pop_expect("pp_r2", 16'h13, 64'h13);
        pop_expect("pp_r3", 16'h14, 64'h14);

        // Control corners
        wrap_mode = 1'b0;
        pulse_arm();
        push(16'hA1, 64'hA1);
        pulse_arm();                       // arm while capturing: no clear
        chk("armcap_count", 64'(count), 64'd1);
        chk("armcap_capt",  64'(capturing), 64'd1);
        arm = 1'b1; stop = 1'b1;           // stop wins
        tick();
        arm = 1'b0; stop = 1'b0;
        chk("armstop_capt",  64'(capturing), 64'd0);
        chk("armstop_count", 64'(count), 64'd1);
        pulse_stop();                      // stop in STOPPED: no effect
        chk("stopstop_count", 64'(count), 64'd1);
        pulse_arm();                       // re-arm from STOPPED
        chk("rearm2_count", 64'(count), 64'd0);
        chk("rearm2_samp",  64'(samples), 64'd0);
        chk("rearm2_capt",  64'(capturing), 64'd1);

        // Synchronous reset mid-capture
        push(16'hB0, 64'hB0);
        push(16'hB1, 64'hB1);
        chk("prerst_count", 64'(count), 64'd2);
        rst = 1'b1; rd_ready = 1'b1;
        tick();
        rst = 1'b0; rd_ready = 1'b0;
        chk("mrst_valid", 64'(rd_valid), 64'd0);
        chk("mrst_count", 64'(count), 64'd0);
        chk("mrst_capt",  64'(capturing), 64'd0);
        chk("mrst_samp",  64'(samples), 64'd0);
        chk("mrst_full",  64'(full), 64'd0);
        chk("mrst_ovf",   64'(overflow), 64'd0);
        push(16'hC0, 64'hC0);
        push(16'hC1, 64'hC1);
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_samp",  64'(samples), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
